// File: rtl/csr_unit_if.sv
// Shared CSR unit types and the instruction-side CSR access bundle.
// The master drives the access; the slave (csr_unit) returns the old value and the illegal flag.
package csr_unit_pkg;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpCSRRW = 3'd1,
        OpCSRRS = 3'd2,
        OpCSRRC = 3'd3,
        OpMret  = 3'd4
    } csr_op_e;

    typedef enum logic [3:0] {
        CauseInsnMisaligned  = 4'd0,
        CauseInsnFault       = 4'd1,
        CauseIllegalInsn     = 4'd2,
        CauseBreakpoint      = 4'd3,
        CauseLoadMisaligned  = 4'd4,
        CauseLoadFault       = 4'd5,
        CauseStoreMisaligned = 4'd6,
        CauseStoreFault      = 4'd7,
        CauseEcallU          = 4'd8,
        CauseEcallM          = 4'd11
    } csr_mcause_e;

endpackage

interface csr_unit_if #(
    parameter int Xlen = 64
) ();
    import csr_unit_pkg::*;

    logic            valid_i;
    csr_op_e         csr_op_i;
    logic [11:0]     csr_addr_i;
    logic [Xlen-1:0] rs1_data_i;
    logic [Xlen-1:0] rd_data_o;
    logic            illegal_o;

    modport master (
        output valid_i, csr_op_i, csr_addr_i, rs1_data_i,
        input  rd_data_o, illegal_o
    );

    modport slave (
        input  valid_i, csr_op_i, csr_addr_i, rs1_data_i,
        output rd_data_o, illegal_o
    );

endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/mret sequencing and interrupt arbitration.
// Optional mcycle/minstret counters are compiled in with CSR_UNIT_COUNTERS_EN.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int          Xlen          = 64,
    parameter int unsigned MHartId       = 0,
    parameter bit          VectoredMtvec = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    csr_unit_if.slave       csr_if,
    input  logic            expt_valid_i,
    input  csr_mcause_e     expt_cause_i,
    input  logic [Xlen-1:0] expt_value_i,
    input  logic [Xlen-1:0] pc_i,
    input  logic            retire_i,
    input  logic            irq_software_i,
    input  logic            irq_timer_i,
    input  logic            irq_external_i,
    output logic            raise_trap_o,
    output logic [Xlen-1:0] trap_vector_o
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMisa     = 12'h301;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMtval    = 12'h343;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    // Interrupt lines indexed 0=software, 1=timer, 2=external.
    localparam int          IrqBitPos [3] = '{3, 7, 11};
    localparam logic [3:0]  IrqCode   [3] = '{4'd3, 4'd7, 4'd11};
    localparam logic [Xlen-1:0] MisaVal =
        {((Xlen == 64) ? 2'd2 : 2'd1), {(Xlen-11){1'b0}}, 9'h100};

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      mip_q, mip_d;
    logic [Xlen-1:2] mtvec_base_q, mtvec_base_d;
    logic            mtvec_mode_q, mtvec_mode_d;
    logic [Xlen-1:0] mscratch_q, mscratch_d;
    logic [Xlen-1:0] mepc_q, mepc_d;
    logic [Xlen-1:0] mcause_q, mcause_d;
    logic [Xlen-1:0] mtval_q, mtval_d;

    logic [Xlen-1:0] rd_data;
    logic [Xlen-1:0] wdata;
    wire  [2:0]      mie_wr_bits;
    logic [2:0]      irq_pending;
    logic [3:0]      irq_code;
    logic            is_csr_op, rs1_nonzero, illegal;
    logic            irq_take, expt_take, mret_take, trap_take, csr_we;

`ifdef CSR_UNIT_COUNTERS_EN
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;

    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`endif

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_irq_map
        assign mie_wr_bits[gi] = wdata[IrqBitPos[gi]];
    end

    assign is_csr_op   = csr_if.csr_op_i inside {OpCSRRW, OpCSRRS, OpCSRRC};
    assign rs1_nonzero = |csr_if.rs1_data_i;
    assign illegal     = csr_if.valid_i && is_csr_op && rs1_nonzero
                         && (csr_if.csr_addr_i[11:10] == 2'b11);

    // Interrupts are masked while in reset so stale pending bits cannot redirect fetch.
    assign irq_pending = mip_q & mie_q;
    assign irq_take    = csr_if.valid_i && !rst_i && mstatus_mie_q && (|irq_pending);
    assign expt_take   = csr_if.valid_i && expt_valid_i;
    assign mret_take   = csr_if.valid_i && (csr_if.csr_op_i == OpMret);
    assign trap_take   = irq_take || expt_take;
    // Set/clear with rs1 == 0 is a pure read and must not disturb counters.
    assign csr_we      = csr_if.valid_i && is_csr_op && !illegal && !trap_take
                         && ((csr_if.csr_op_i == OpCSRRW) || rs1_nonzero);

    assign raise_trap_o     = trap_take || mret_take;
    assign csr_if.illegal_o = illegal;
    assign csr_if.rd_data_o = rd_data;

    always_comb begin
        irq_code = IrqCode[1];
        if (irq_pending[2]) begin
            irq_code = IrqCode[2];
        end else if (irq_pending[0]) begin
            irq_code = IrqCode[0];
        end
    end

    always_comb begin
        trap_vector_o = {mtvec_base_q, 2'b00};
        if (mret_take && !trap_take) begin
            trap_vector_o = mepc_q;
        end else if (irq_take && mtvec_mode_q) begin
            trap_vector_o = {mtvec_base_q, 2'b00} + {{(Xlen-6){1'b0}}, irq_code, 2'b00};
        end
    end

    always_comb begin
        rd_data = '0;
        case (csr_if.csr_addr_i)
            AddrMhartid:  rd_data = Xlen'(MHartId);
            AddrMisa:     rd_data = MisaVal;
            AddrMstatus: begin
                rd_data[3]     = mstatus_mie_q;
                rd_data[7]     = mstatus_mpie_q;
                rd_data[12:11] = 2'b11;
            end
            AddrMie: begin
                for (int i = 0; i < 3; i++) rd_data[IrqBitPos[i]] = mie_q[i];
            end
            AddrMip: begin
                for (int i = 0; i < 3; i++) rd_data[IrqBitPos[i]] = mip_q[i];
            end
            AddrMtvec:    rd_data = {mtvec_base_q, 1'b0, mtvec_mode_q};
            AddrMscratch: rd_data = mscratch_q;
            AddrMepc:     rd_data = mepc_q;
            AddrMcause:   rd_data = mcause_q;
            AddrMtval:    rd_data = mtval_q;
`ifdef CSR_UNIT_COUNTERS_EN
            AddrMcycle:    rd_data = mcycle_q[Xlen-1:0];
            AddrMinstret:  rd_data = minstret_q[Xlen-1:0];
            AddrMcycleh:   if (Xlen == 32) rd_data[31:0] = mcycle_q[63:32];
            AddrMinstreth: if (Xlen == 32) rd_data[31:0] = minstret_q[63:32];
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (csr_if.csr_op_i)
            OpCSRRS: wdata = rd_data | csr_if.rs1_data_i;
            OpCSRRC: wdata = rd_data & ~csr_if.rs1_data_i;
            default: wdata = csr_if.rs1_data_i;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mip_d          = {irq_external_i, irq_timer_i, irq_software_i};
        mtvec_base_d   = mtvec_base_q;
        mtvec_mode_d   = mtvec_mode_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_take) begin
            mepc_d         = {pc_i[Xlen-1:1], 1'b0};
            mcause_d       = irq_take ? {1'b1, {(Xlen-5){1'b0}}, irq_code}
                                      : {{(Xlen-4){1'b0}}, expt_cause_i};
            mtval_d        = irq_take ? '0 : expt_value_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_if.csr_addr_i)
                AddrMstatus: begin
                    mstatus_mie_d  = wdata[3];
                    mstatus_mpie_d = wdata[7];
                end
                AddrMie:      mie_d = mie_wr_bits;
                AddrMtvec: begin
                    mtvec_base_d = wdata[Xlen-1:2];
                    // Reserved modes 2/3 leave the current mode in place.
                    if (wdata[1:0] == 2'b00) begin
                        mtvec_mode_d = 1'b0;
                    end else if (wdata[1:0] == 2'b01) begin
                        mtvec_mode_d = VectoredMtvec;
                    end
                end
                AddrMscratch: mscratch_d = wdata;
                AddrMepc:     mepc_d     = {wdata[Xlen-1:1], 1'b0};
                AddrMcause:   mcause_d   = wdata;
                AddrMtval:    mtval_d    = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_base_q   <= '0;
            mtvec_mode_q   <= 1'b0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_base_q   <= mtvec_base_d;
            mtvec_mode_q   <= mtvec_mode_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_UNIT_COUNTERS_EN
    // A software write replaces the increment for that cycle; the untouched half holds.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire_i};
        if (csr_we) begin
            case (csr_if.csr_addr_i)
                AddrMcycle: begin
                    mcycle_d            = mcycle_q;
                    mcycle_d[Xlen-1:0]  = wdata;
                end
                AddrMinstret: begin
                    minstret_d           = minstret_q;
                    minstret_d[Xlen-1:0] = wdata;
                end
                AddrMcycleh: if (Xlen == 32) begin
                    mcycle_d        = mcycle_q;
                    mcycle_d[63:32] = wdata[31:0];
                end
                AddrMinstreth: if (Xlen == 32) begin
                    minstret_d        = minstret_q;
                    minstret_d[63:32] = wdata[31:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

endmodule
